// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the bit-serial ALU sequencer.
// Imported by alu_seq.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic OP_CNT = 1'b0;
  localparam logic OP_SHL = 1'b1;

  function automatic int unsigned clamp_len(
    input int unsigned len,
    input int unsigned w
  );
    return (len > w) ? w : len;
  endfunction

endpackage

// File: rtl/alu_seq.sv
// Bit-serial sequencer feeding the alu stage: streams a word MSB-first
// into alu_in_a_lsb while holding the accumulator on alu_in_b.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int alu_width = 12,
  parameter int cnt_width = $clog2(alu_width + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_op,
  input  logic [alu_width-1:0] in_word,
  input  logic [cnt_width-1:0] in_len,
  input  logic [alu_width-1:0] in_acc_init,
  output logic                 alu_in_a_lsb,
  output logic                 alu_op,
  output logic [alu_width-1:0] alu_in_b,
  input  logic [alu_width-1:0] alu_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [alu_width-1:0] out_result
);

  state_t               state;
  logic [alu_width-1:0] sreg;
  logic [alu_width-1:0] acc;
  logic [cnt_width-1:0] cnt;
  logic                 op_r;

  logic [cnt_width-1:0] len_c;
  logic [cnt_width-1:0] sh_amt;

  assign len_c = cnt_width'(
    clamp_len(32'(in_len), alu_width));

  // Left-align the L-bit field so bit L-1 lands on sreg MSB.
  assign sh_amt = cnt_width'(alu_width) - len_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      acc   <= '0;
      cnt   <= '0;
      op_r  <= OP_CNT;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg  <= in_word << sh_amt;
            acc   <= in_acc_init;
            cnt   <= len_c;
            op_r  <= in_op;
            state <= (len_c != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          acc  <= alu_out;
          sreg <= sreg << 1;
          cnt  <= cnt - cnt_width'(1);
          if (cnt == cnt_width'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready     = (state == IDLE);
  assign out_valid    = (state == DONE);
  assign out_result   = acc;
  assign alu_in_a_lsb = (state == RUN) & sreg[alu_width-1];
  assign alu_op       = op_r;
  assign alu_in_b     = acc;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq paired with a behavioural alu.
// Table-driven jobs plus backpressure and mid-run reset sequences.
module tb_alu_seq;

  localparam int W  = 12;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_op;
  logic [W-1:0]  in_word;
  logic [CW-1:0] in_len;
  logic [W-1:0]  in_acc_init;
  logic          alu_in_a_lsb;
  logic          alu_op;
  logic [W-1:0]  alu_in_b;
  logic [W-1:0]  alu_out;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // alu contract: CNT adds the bit, SHL shifts it in
  assign alu_out = alu_op
    ? {alu_in_b[W-2:0], alu_in_a_lsb}
    : alu_in_b + W'(alu_in_a_lsb);

  alu_seq #(.alu_width(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_word      (in_word),
    .in_len       (in_len),
    .in_acc_init  (in_acc_init),
    .alu_in_a_lsb (alu_in_a_lsb),
    .alu_op       (alu_op),
    .alu_in_b     (alu_in_b),
    .alu_out      (alu_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result)
  );

  typedef struct {
    string         name;
    logic          op;
    logic [W-1:0]  word;
    logic [CW-1:0] len;
    logic [W-1:0]  init;
    int            eff_len;
    logic [W-1:0]  bits;
    logic [W-1:0]  result;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(
    input logic          op,
    input logic [W-1:0]  word,
    input logic [CW-1:0] len,
    input logic [W-1:0]  init
  );
    in_op       = op;
    in_word     = word;
    in_len      = len;
    in_acc_init = init;
    in_valid    = 1'b1;
    step();
    in_valid    = 1'b0;
  endtask

  // Runs one job; stream bit for RUN cycle j is bits[L-j].
  task automatic run_vec(input vec_t v);
    chk({v.name, " in_ready idle"}, 32'(in_ready), 1);
    accept(v.op, v.word, v.len, v.init);
    for (int j = 1; j <= v.eff_len; j++) begin
      chk({v.name, " bit"}, 32'(alu_in_a_lsb),
          32'(v.bits[v.eff_len-j]));
      chk({v.name, " no early valid"},
          32'(out_valid), 0);
      chk({v.name, " alu_op"}, 32'(alu_op), 32'(v.op));
      step();
    end
    chk({v.name, " out_valid"}, 32'(out_valid), 1);
    chk({v.name, " result"}, 32'(out_result),
        32'(v.result));
    chk({v.name, " lsb idle in done"},
        32'(alu_in_a_lsb), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({v.name, " in_ready after"}, 32'(in_ready), 1);
    chk({v.name, " valid drop"}, 32'(out_valid), 0);
  endtask

  initial begin
    vecs[0] = '{"cnt_pop", 1'b0, 12'hA5C, 4'd12,
                12'h000, 12, 12'hA5C, 12'h006};
    vecs[1] = '{"shl_rebuild", 1'b1, 12'h0B3, 4'd8,
                12'h000, 8, 12'h0B3, 12'h0B3};
    vecs[2] = '{"wrap_clamp", 1'b0, 12'hFFF, 4'd15,
                12'hFFA, 12, 12'hFFF, 12'h006};
    vecs[3] = '{"zero_len", 1'b0, 12'hFFF, 4'd0,
                12'h123, 0, 12'h000, 12'h123};
    vecs[4] = '{"shl_mask", 1'b1, 12'h0F0, 4'd4,
                12'h001, 4, 12'h000, 12'h010};
    vecs[5] = '{"cnt_short", 1'b0, 12'hFFF, 4'd3,
                12'h005, 3, 12'h007, 12'h008};

    rst         = 1'b1;
    in_valid    = 1'b0;
    in_op       = 1'b0;
    in_word     = '0;
    in_len      = '0;
    in_acc_init = '0;
    out_ready   = 1'b0;
    step();
    step();
    rst = 1'b0;

    chk("rst in_ready", 32'(in_ready), 1);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_result", 32'(out_result), 0);
    chk("rst a_lsb", 32'(alu_in_a_lsb), 0);
    chk("rst alu_op", 32'(alu_op), 0);
    chk("rst alu_in_b", 32'(alu_in_b), 0);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
      step();
    end

    // Backpressure: result held, new requests ignored
    accept(1'b0, 12'h00F, 4'd4, 12'h000);
    for (int j = 0; j < 4; j++) step();
    chk("bp valid rise", 32'(out_valid), 1);
    for (int j = 0; j < 5; j++) begin
      in_valid    = j[0];
      in_word     = 12'hFFF;
      in_len      = 4'd12;
      in_acc_init = 12'h777;
      step();
      chk("bp valid held", 32'(out_valid), 1);
      chk("bp result held", 32'(out_result), 32'h4);
      chk("bp in_ready low", 32'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp in_ready back", 32'(in_ready), 1);
    chk("bp valid clear", 32'(out_valid), 0);
    step();
    chk("bp no accept", 32'(in_ready), 1);

    // Reset on RUN cycle 5 aborts the job
    accept(1'b1, 12'hFFF, 4'd12, 12'h055);
    for (int j = 1; j < 5; j++) step();
    chk("rr in run", 32'(in_ready), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rr in_ready", 32'(in_ready), 1);
    chk("rr out_valid", 32'(out_valid), 0);
    chk("rr alu_in_b", 32'(alu_in_b), 0);
    chk("rr alu_op", 32'(alu_op), 0);
    chk("rr a_lsb", 32'(alu_in_a_lsb), 0);
    begin
      int seen = 0;
      out_ready = 1'b1;
      for (int j = 0; j < 20; j++) begin
        if (out_valid) seen++;
        step();
      end
      out_ready = 1'b0;
      chk("rr no result", 32'(seen), 0);
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
